// File: rtl/vx_rf_bank_arbiter.sv
// Register-file bank arbiter: per-bank round-robin grant of collector read requests,
// registered bank read and response steering. Optional conflict counter under RF_ARB_PERF_EN.
module vx_rf_bank_arbiter #(
   parameter int NUM_REQS    = 4,
   parameter int NUM_BANKS   = 4,
   parameter int REG_BITS    = 8,
   localparam int BANK_SEL_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int BANK_ADDR_W = REG_BITS - $clog2(NUM_BANKS)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQS-1:0]               req_valid,
   input  logic [NUM_REQS*REG_BITS-1:0]      req_reg,
   output logic [NUM_REQS-1:0]               req_ready,
   output logic [NUM_BANKS-1:0]              bank_rd_en,
   output logic [NUM_BANKS*BANK_ADDR_W-1:0]  bank_rd_addr,
   output logic [NUM_REQS-1:0]               rsp_valid,
   output logic [NUM_REQS*BANK_SEL_W-1:0]    rsp_bank_sel
`ifdef RF_ARB_PERF_EN
  ,output logic [43:0]                       perf_conflicts
`endif
);

   localparam int LOG_B = $clog2(NUM_BANKS);
   localparam int REQ_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

   function automatic logic [BANK_SEL_W-1:0] bank_of(input logic [BANK_SEL_W-1:0] low_bits);
      if (NUM_BANKS == 1) begin
         return {BANK_SEL_W{1'b0}};
      end else begin
         return low_bits;
      end
   endfunction

   logic [BANK_SEL_W-1:0]            bank_s   [NUM_REQS];
   logic [BANK_ADDR_W-1:0]           row_s    [NUM_REQS];
   logic [REQ_W-1:0]                 winner_s [NUM_BANKS];
   logic [REQ_W-1:0]                 rr_ptr_r [NUM_BANKS];
   logic [NUM_BANKS-1:0]             grant_s;
   logic [NUM_REQS-1:0]              ready_s;
   logic [NUM_BANKS-1:0]             bank_rd_en_r;
   logic [NUM_BANKS*BANK_ADDR_W-1:0] bank_rd_addr_r;
   logic [NUM_REQS-1:0]              rsp_valid_r;
   logic [NUM_REQS*BANK_SEL_W-1:0]   rsp_bank_sel_r;

   // Split each request register index into bank select and bank row.
   always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
         bank_s[i] = bank_of(req_reg[i*REG_BITS +: BANK_SEL_W]);
         row_s[i]  = req_reg[i*REG_BITS + LOG_B +: BANK_ADDR_W];
      end
   end

   // Per-bank cyclic search from rr_ptr; scanning downward lets the nearest candidate overwrite last.
   always_comb begin
      int   idx_v;
      logic cand_v;
      idx_v  = 0;
      cand_v = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         grant_s[b]  = 1'b0;
         winner_s[b] = {REQ_W{1'b0}};
         for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx_v       = int'(rr_ptr_r[b]) + k;
            idx_v       = (idx_v >= NUM_REQS) ? (idx_v - NUM_REQS) : idx_v;
            cand_v      = req_valid[idx_v] && (bank_s[idx_v] == BANK_SEL_W'(b));
            grant_s[b]  = grant_s[b] | cand_v;
            winner_s[b] = cand_v ? REQ_W'(idx_v) : winner_s[b];
         end
         grant_s[b] = grant_s[b] & ~reset;
      end
   end

   // Fold per-bank winners back into per-collector grants.
   always_comb begin
      ready_s = {NUM_REQS{1'b0}};
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            ready_s[i] = ready_s[i] | (grant_s[b] && (winner_s[b] == REQ_W'(i)));
         end
      end
   end

   // Round-robin pointers advance past the winner only on a grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            rr_ptr_r[b] <= {REQ_W{1'b0}};
         end
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (grant_s[b]) begin
               rr_ptr_r[b] <= (winner_s[b] == REQ_W'(NUM_REQS - 1)) ? {REQ_W{1'b0}}
                                                                    : (winner_s[b] + 1'b1);
            end
         end
      end
   end

   // Bank read issue and response steering, one cycle after the grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_rd_en_r   <= {NUM_BANKS{1'b0}};
         bank_rd_addr_r <= {(NUM_BANKS*BANK_ADDR_W){1'b0}};
         rsp_valid_r    <= {NUM_REQS{1'b0}};
         rsp_bank_sel_r <= {(NUM_REQS*BANK_SEL_W){1'b0}};
      end else begin
         bank_rd_en_r <= grant_s;
         rsp_valid_r  <= ready_s;
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (grant_s[b]) begin
               bank_rd_addr_r[b*BANK_ADDR_W +: BANK_ADDR_W] <= row_s[winner_s[b]];
            end
         end
         for (int i = 0; i < NUM_REQS; i++) begin
            if (ready_s[i]) begin
               rsp_bank_sel_r[i*BANK_SEL_W +: BANK_SEL_W] <= bank_s[i];
            end
         end
      end
   end

   // Reset also squashes a response already in flight in the same cycle.
   assign req_ready    = ready_s;
   assign bank_rd_en   = bank_rd_en_r & {NUM_BANKS{~reset}};
   assign bank_rd_addr = bank_rd_addr_r & {(NUM_BANKS*BANK_ADDR_W){~reset}};
   assign rsp_valid    = rsp_valid_r & {NUM_REQS{~reset}};
   assign rsp_bank_sel = rsp_bank_sel_r & {(NUM_REQS*BANK_SEL_W){~reset}};

`ifdef RF_ARB_PERF_EN
   logic [43:0] perf_conflicts_r;

   // Count cycles in which some valid request was left waiting.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_conflicts_r <= 44'd0;
      end else if (|(req_valid & ~ready_s)) begin
         perf_conflicts_r <= perf_conflicts_r + 44'd1;
      end else begin
         perf_conflicts_r <= perf_conflicts_r;
      end
   end

   assign perf_conflicts = perf_conflicts_r & {44{~reset}};
`endif

endmodule

// File: tb/tb_vx_rf_bank_arbiter.sv
// Self-checking bench for vx_rf_bank_arbiter: directed scenarios plus randomized traffic
// checked against a distance-based round-robin reference model.
module tb_vx_rf_bank_arbiter;

   localparam int NR = 4;
   localparam int NB = 4;
   localparam int AW = 6;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    req_valid = 4'b0;
   logic [31:0]   req_reg = 32'h0;
   logic [3:0]    req_ready;
   logic [3:0]    bank_rd_en;
   logic [23:0]   bank_rd_addr;
   logic [3:0]    rsp_valid;
   logic [7:0]    rsp_bank_sel;
`ifdef RF_ARB_PERF_EN
   logic [43:0]   perf_conflicts;
`endif

   vx_rf_bank_arbiter #(.NUM_REQS(NR), .NUM_BANKS(NB), .REG_BITS(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_reg      (req_reg),
      .req_ready    (req_ready),
      .bank_rd_en   (bank_rd_en),
      .bank_rd_addr (bank_rd_addr),
      .rsp_valid    (rsp_valid),
      .rsp_bank_sel (rsp_bank_sel)
`ifdef RF_ARB_PERF_EN
     ,.perf_conflicts (perf_conflicts)
`endif
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;

   // Reference model state
   int          m_rr  [NB];
   int          m_win [NB];
   logic [3:0]  m_ready;
   logic [3:0]  e_en = 4'b0;
   logic [5:0]  e_addr [NB];
   logic [3:0]  e_rv = 4'b0;
   logic [1:0]  e_sel [NR];
   logic [43:0] e_perf = 44'd0;

   // Winner per bank = valid requester with the smallest cyclic distance from the pointer.
   task automatic model_eval();
      int d;
      int bestd;
      m_ready = 4'b0;
      for (int b = 0; b < NB; b++) begin
         m_win[b] = -1;
         bestd = NR;
         if (!reset) begin
            for (int i = 0; i < NR; i++) begin
               if (req_valid[i] && req_reg[i*8 +: 2] == 2'(b)) begin
                  d = (i - m_rr[b] + NR) % NR;
                  if (d < bestd) begin
                     bestd = d;
                     m_win[b] = i;
                  end
               end
            end
         end
         if (m_win[b] >= 0) m_ready[m_win[b]] = 1'b1;
      end
   endtask

   task automatic drive(input logic rst, input logic [3:0] v, input logic [31:0] r);
      @(negedge clk);
      reset = rst;
      req_valid = v;
      req_reg = r;
      #1;
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      if (reset) begin
         for (int b = 0; b < NB; b++) m_rr[b] = 0;
         e_en = 4'b0;
         e_rv = 4'b0;
         e_perf = 44'd0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            e_en[b] = (m_win[b] >= 0);
            if (m_win[b] >= 0) begin
               e_addr[b] = req_reg[m_win[b]*8 + 2 +: 6];
               m_rr[b] = (m_win[b] + 1) % NR;
            end
         end
         e_rv = m_ready;
         for (int i = 0; i < NR; i++) if (m_ready[i]) e_sel[i] = req_reg[i*8 +: 2];
         if ((req_valid & ~m_ready) != 4'b0) e_perf = e_perf + 44'd1;
      end
   endtask

   task automatic test_reset();
      drive(1'b1, 4'b1111, 32'h0C080400);
      advance();
      drive(1'b1, 4'b1111, 32'h0C080400);
      vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
      vectors++; if (bank_rd_en !== 4'b0) begin miscompares++; $display("FAIL reset_rd_en got %b exp 0000", bank_rd_en); end
      vectors++; if (rsp_valid !== 4'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
      advance();
      drive(1'b0, 4'b0000, 32'h0);
      vectors++; if (bank_rd_addr !== 24'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", bank_rd_addr); end
      vectors++; if (rsp_bank_sel !== 8'h0) begin miscompares++; $display("FAIL reset_sel got %h exp 0", rsp_bank_sel); end
      vectors++; if (rsp_valid !== 4'b0 || bank_rd_en !== 4'b0) begin miscompares++; $display("FAIL reset_after got %b/%b exp 0/0", rsp_valid, bank_rd_en); end
      advance();
   endtask

   task automatic test_parallel();
      drive(1'b0, 4'b0011, 32'h00000A05);
      vectors++; if (req_ready !== 4'b0011) begin miscompares++; $display("FAIL par_ready got %b exp 0011", req_ready); end
      advance();
      drive(1'b0, 4'b0000, 32'h0);
      vectors++; if (bank_rd_en !== 4'b0110) begin miscompares++; $display("FAIL par_rd_en got %b exp 0110", bank_rd_en); end
      vectors++; if (bank_rd_addr[6 +: 6] !== 6'h01) begin miscompares++; $display("FAIL par_addr1 got %h exp 01", bank_rd_addr[6 +: 6]); end
      vectors++; if (bank_rd_addr[12 +: 6] !== 6'h02) begin miscompares++; $display("FAIL par_addr2 got %h exp 02", bank_rd_addr[12 +: 6]); end
      vectors++; if (rsp_valid !== 4'b0011) begin miscompares++; $display("FAIL par_rsp_valid got %b exp 0011", rsp_valid); end
      vectors++; if (rsp_bank_sel[3:0] !== 4'b1001) begin miscompares++; $display("FAIL par_sel got sel0=%0d sel1=%0d exp 1,2", rsp_bank_sel[1:0], rsp_bank_sel[3:2]); end
      advance();
   endtask

   task automatic test_same_bank();
      logic [3:0] pend;
      pend = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, pend, 32'h04040404);
         vectors++; if (req_ready !== ((k < 4) ? (4'b0001 << k) : 4'b0000)) begin miscompares++; $display("FAIL same_bank_ready step %0d got %b", k, req_ready); end
         vectors++; if (rsp_valid !== ((k > 0) ? (4'b0001 << (k - 1)) : 4'b0000)) begin miscompares++; $display("FAIL same_bank_rsp step %0d got %b", k, rsp_valid); end
         if (k > 0) begin
            vectors++; if (bank_rd_en !== 4'b0001 || bank_rd_addr[5:0] !== 6'h01) begin miscompares++; $display("FAIL same_bank_rd step %0d got en=%b addr=%h exp 0001/01", k, bank_rd_en, bank_rd_addr[5:0]); end
         end
         pend = pend & ~m_ready;
         advance();
      end
   endtask

   task automatic test_rr_pointer();
      drive(1'b0, 4'b0010, 32'h00000000);
      advance();
      drive(1'b0, 4'b1001, 32'h0C000010);
      vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL rr_first got %b exp 1000", req_ready); end
      advance();
      drive(1'b0, 4'b0001, 32'h0C000010);
      vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rr_second got %b exp 0001", req_ready); end
      vectors++; if (rsp_valid !== 4'b1000 || rsp_bank_sel[7:6] !== 2'd0) begin miscompares++; $display("FAIL rr_rsp got %b sel3=%0d exp 1000/0", rsp_valid, rsp_bank_sel[7:6]); end
      advance();
      drive(1'b0, 4'b0000, 32'h0);
      advance();
   endtask

   task automatic test_reset_inflight();
      drive(1'b0, 4'b0001, 32'h00000008);
      vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL inflight_grant got %b exp 0001", req_ready); end
      advance();
      drive(1'b1, 4'b1111, 32'h0);
      vectors++; if (rsp_valid !== 4'b0 || bank_rd_en !== 4'b0) begin miscompares++; $display("FAIL inflight_drop got rsp=%b en=%b exp 0/0", rsp_valid, bank_rd_en); end
      vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL inflight_ready got %b exp 0000", req_ready); end
      advance();
      drive(1'b0, 4'b1001, 32'h10000004);
      vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL inflight_rr got %b exp 0001", req_ready); end
      advance();
      drive(1'b0, 4'b1000, 32'h10000004);
      advance();
      drive(1'b0, 4'b0000, 32'h0);
      advance();
   endtask

   task automatic test_drop();
      drive(1'b0, 4'b0101, 32'h00070003);
      vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL drop_busy got %b exp 0001", req_ready); end
      advance();
      drive(1'b0, 4'b0000, 32'h0);
      vectors++; if (rsp_valid !== 4'b0001 || bank_rd_en !== 4'b1000) begin miscompares++; $display("FAIL drop_rsp got rsp=%b en=%b exp 0001/1000", rsp_valid, bank_rd_en); end
      advance();
      drive(1'b0, 4'b0000, 32'h0);
      vectors++; if (rsp_valid !== 4'b0 || bank_rd_en !== 4'b0) begin miscompares++; $display("FAIL drop_idle got rsp=%b en=%b exp 0/0", rsp_valid, bank_rd_en); end
      advance();
   endtask

`ifdef RF_ARB_PERF_EN
   task automatic test_perf();
      logic [3:0] pend;
      drive(1'b1, 4'b0000, 32'h0);
      advance();
      pend = 4'b0111;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, pend, 32'h00080400);
         pend = pend & ~m_ready;
         advance();
      end
      drive(1'b0, 4'b0000, 32'h0);
      vectors++; if (perf_conflicts !== 44'd2) begin miscompares++; $display("FAIL perf_count got %0d exp 2", perf_conflicts); end
      advance();
   endtask
`endif

   task automatic test_random();
      logic [3:0]  pv;
      logic [7:0]  pr [NR];
      pv = 4'b0;
      for (int i = 0; i < NR; i++) pr[i] = 8'h00;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!pv[i]) begin
               if ($urandom_range(1, 0) == 1) begin
                  pv[i] = 1'b1;
                  pr[i] = 8'($urandom_range(255, 0));
               end
            end else if ($urandom_range(15, 0) == 0) begin
               pv[i] = 1'b0;
            end
         end
         drive(1'b0, pv, {pr[3], pr[2], pr[1], pr[0]});
         vectors++; if (req_ready !== m_ready) begin miscompares++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, req_ready, m_ready); end
         vectors++; if (rsp_valid !== e_rv) begin miscompares++; $display("FAIL rand_rsp_valid cyc %0d got %b exp %b", c, rsp_valid, e_rv); end
         vectors++; if (bank_rd_en !== e_en) begin miscompares++; $display("FAIL rand_rd_en cyc %0d got %b exp %b", c, bank_rd_en, e_en); end
         for (int b = 0; b < NB; b++) begin
            if (e_en[b]) begin
               vectors++; if (bank_rd_addr[b*AW +: AW] !== e_addr[b]) begin miscompares++; $display("FAIL rand_addr cyc %0d bank %0d got %h exp %h", c, b, bank_rd_addr[b*AW +: AW], e_addr[b]); end
            end
         end
         for (int i = 0; i < NR; i++) begin
            if (e_rv[i]) begin
               vectors++; if (rsp_bank_sel[i*SW +: SW] !== e_sel[i]) begin miscompares++; $display("FAIL rand_sel cyc %0d req %0d got %0d exp %0d", c, i, rsp_bank_sel[i*SW +: SW], e_sel[i]); end
            end
         end
`ifdef RF_ARB_PERF_EN
         vectors++; if (perf_conflicts !== e_perf) begin miscompares++; $display("FAIL rand_perf cyc %0d got %0d exp %0d", c, perf_conflicts, e_perf); end
`endif
         advance();
         pv = pv & ~m_ready;
      end
      drive(1'b0, 4'b0000, 32'h0);
      advance();
   endtask

   initial begin
      for (int b = 0; b < NB; b++) begin
         m_rr[b] = 0;
         m_win[b] = -1;
         e_addr[b] = 6'h0;
      end
      for (int i = 0; i < NR; i++) e_sel[i] = 2'd0;
      test_reset();
      test_parallel();
      test_same_bank();
      test_rr_pointer();
      test_reset_inflight();
      test_drop();
`ifdef RF_ARB_PERF_EN
      test_perf();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
